// File: rtl/ahb_ap_burst_if.sv
// Bundle of the AFT-side FIFO and bus signals used by the AHB access point.
// The master modport is the access point; slave is the FIFO/bus environment.
interface ahb_ap_burst_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [40:0]       rdata_fifo1;
  logic              rempty;
  logic              rinc;
  logic [33:0]       wdata_fifo2;
  logic              wfull;
  logic              winc;
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr_aft;
  logic [31:0]       wdata_aft;
  logic [3:0]        byte_en;
  logic              busy;
  logic [31:0]       rdata_aft;
  logic              error;
  logic              ap_active;
  logic              proto_err;

  modport master (
    input  rdata_fifo1, rempty, wfull, busy, rdata_aft, error,
    output rinc, wdata_fifo2, winc, ren, wen, addr_aft, wdata_aft, byte_en, ap_active, proto_err
  );

  modport slave (
    output rdata_fifo1, rempty, wfull, busy, rdata_aft, error,
    input  rinc, wdata_fifo2, winc, ren, wen, addr_aft, wdata_aft, byte_en, ap_active, proto_err
  );
endinterface

// File: rtl/ahb_ap_burst.sv
// AHB access point for the AFT domain: pops setup/data command words, runs single or
// incrementing-burst bus transfers and pushes read data / write status to the response FIFO.
module ahb_ap_burst #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 5,
  parameter bit          AUTO_INC = 1'b1,
  parameter bit          WRAP_KB  = 1'b1
) (
  input logic            AFT_CLK,
  input logic            TRST,
  ahb_ap_burst_if.master bus
);

  typedef enum logic [2:0] {StIdle, StWdata, StXfer, StResp, StDrain} state_e;

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [CNT_W-1:0]  left;
  logic              rw;
  logic              err;
  logic              perr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  logic              cmd_sel;
  logic [1:0]        cmd_size;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_payload;
  logic              last;
  logic [ADDR_W-1:0] addr_out;

  assign cmd_rw      = bus.rdata_fifo1[0];
  assign cmd_cnt     = bus.rdata_fifo1[1 +: CNT_W];
  assign cmd_size    = bus.rdata_fifo1[7:6];
  assign cmd_sel     = bus.rdata_fifo1[8];
  assign cmd_payload = bus.rdata_fifo1[40:9];
  assign cmd_addr    = cmd_payload[ADDR_W-1:0];

  // A write with an error still closes the burst even if beats remain.
  assign last = (left == '0) || err;

  // Step by the transfer size; with WRAP_KB the upper address bits never change.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] sz);
    logic [2:0]        step;
    logic [ADDR_W-1:0] sum;
    step = (sz == 2'b00) ? 3'd1 : (sz == 2'b01) ? 3'd2 : 3'd4;
    sum  = a + ADDR_W'(step);
    if (WRAP_KB) sum = {a[ADDR_W-1:10], sum[9:0]};
    return AUTO_INC ? sum : a;
  endfunction

  // Force natural alignment on the bus address for half and word transfers.
  always_comb begin
    addr_out = addr;
    if (size[1]) addr_out[1:0] = 2'b00;
    else if (size[0]) addr_out[0] = 1'b0;
  end

  // Byte-lane decode from the unaligned beat address; lanes are quiet outside XFER.
  always_comb begin
    bus.byte_en = 4'b0000;
    if (state == StXfer) begin
      if (size[1]) bus.byte_en = 4'b1111;
      else if (size[0]) bus.byte_en = addr[1] ? 4'b1100 : 4'b0011;
      else bus.byte_en = 4'b0001 << addr[1:0];
    end
  end

  assign bus.ren         = (state == StXfer) && !rw;
  assign bus.wen         = (state == StXfer) && rw;
  assign bus.addr_aft    = addr_out;
  assign bus.wdata_aft   = wdata;
  assign bus.ap_active   = (state != StIdle);
  assign bus.proto_err   = perr;
  assign bus.winc        = (state == StResp) && !bus.wfull;
  assign bus.wdata_fifo2 = (state == StResp) ? {err, last, rw ? 32'h0 : rdata} : 34'h0;
  // Setups are only ever popped in IDLE; WDATA and DRAIN pop data words only.
  assign bus.rinc        = !bus.rempty &&
                           ((state == StIdle) ||
                            (((state == StWdata) || (state == StDrain)) && !cmd_sel));

  // Command sequencing, beat bookkeeping and sticky protocol error.
  always_ff @(posedge AFT_CLK or posedge TRST) begin
    if (TRST) begin
      state <= StIdle;
      addr  <= '0;
      size  <= '0;
      left  <= '0;
      rw    <= 1'b0;
      err   <= 1'b0;
      perr  <= 1'b0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (!bus.rempty) begin
            if (cmd_sel) begin
              addr  <= cmd_addr;
              size  <= cmd_size;
              left  <= cmd_cnt;
              rw    <= cmd_rw;
              err   <= 1'b0;
              state <= cmd_rw ? StWdata : StXfer;
            end else begin
              perr <= 1'b1;
            end
          end
        end
        StWdata: begin
          if (!bus.rempty) begin
            if (!cmd_sel) begin
              wdata <= cmd_payload;
              state <= StXfer;
            end else begin
              // Leave the setup in the FIFO so IDLE picks it up next.
              perr  <= 1'b1;
              err   <= 1'b0;
              state <= StIdle;
            end
          end
        end
        StXfer: begin
          if (!bus.busy) begin
            err <= err | bus.error;
            if (!rw) begin
              rdata <= bus.rdata_aft;
              state <= StResp;
            end else if (bus.error || (left == '0)) begin
              state <= StResp;
            end else begin
              left  <= left - CNT_W'(1);
              addr  <= next_addr(addr, size);
              state <= StWdata;
            end
          end
        end
        StResp: begin
          if (!bus.wfull) begin
            if (!rw && !last) begin
              left  <= left - CNT_W'(1);
              addr  <= next_addr(addr, size);
              state <= StXfer;
            end else if (rw && err && (left != '0)) begin
              state <= StDrain;
            end else begin
              err   <= 1'b0;
              state <= StIdle;
            end
          end
        end
        StDrain: begin
          if (!bus.rempty) begin
            if (!cmd_sel) begin
              left <= left - CNT_W'(1);
              if (left == CNT_W'(1)) state <= StIdle;
            end else begin
              perr  <= 1'b1;
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ap_burst.sv
// Randomised self-checking bench for ahb_ap_burst with a transaction-level reference model.
module tb_ahb_ap_burst;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wr;
  } beat_t;

  logic clk;
  logic rst;

  ahb_ap_burst_if #(.ADDR_W(32)) bus ();

  ahb_ap_burst #(
    .ADDR_W  (32),
    .CNT_W   (5),
    .AUTO_INC(1'b1),
    .WRAP_KB (1'b1)
  ) dut (
    .AFT_CLK(clk),
    .TRST   (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [40:0] f1[$];
  logic [31:0] rd_vals[$];
  beat_t       exp_beats[$];
  logic [33:0] exp_resp[$];
  int          err_beat  = -1;
  int          beat_cnt  = 0;
  int          full_left = 0;
  bit          rnd_gap   = 0;
  bit          rnd_busy  = 0;
  bit          rnd_full  = 0;
  bit          force_busy = 0;
  logic        exp_perr  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [40:0] setup_w(input logic [31:0] a, input logic [1:0] sz,
                                          input int cnt, input logic rw);
    logic [4:0] c;
    c = 5'(cnt);
    return {a, 1'b1, sz, c, rw};
  endfunction

  function automatic logic [40:0] data_w(input logic [31:0] d);
    return {d, 9'h000};
  endfunction

  // Closed-form address of beat k: base plus k steps, wrapping inside the 1KB block.
  function automatic logic [31:0] beat_raw(input logic [31:0] a, input logic [1:0] sz,
                                           input int k);
    logic [31:0] step;
    logic [31:0] s;
    step = (sz == 2'd0) ? 32'd1 : (sz == 2'd1) ? 32'd2 : 32'd4;
    s = a + step * 32'(k);
    return {a[31:10], s[9:0]};
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] sz);
    if (sz >= 2'd2) return {a[31:2], 2'b00};
    if (sz == 2'd1) return {a[31:1], 1'b0};
    return a;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [1:0] sz);
    if (sz >= 2'd2) return 4'hF;
    if (sz == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  // Queue the command words and the beats/responses the bus and fifo2 should see.
  task automatic expect_cmd(input logic [31:0] a, input logic [1:0] sz, input int cnt,
                            input logic rw, input int eb);
    int          nb;
    bit          bad;
    logic [31:0] d;
    logic [31:0] raw;
    beat_t       b;
    bad = (eb >= 0) && (eb <= cnt);
    nb  = bad ? eb + 1 : cnt + 1;
    err_beat = eb;
    beat_cnt = 0;
    rd_vals.delete();
    f1.push_back(setup_w(a, sz, cnt, rw));
    for (int k = 0; k <= cnt; k++) begin
      d = $urandom;
      if (rw) f1.push_back(data_w(d));
      else rd_vals.push_back(d);
      if (k < nb) begin
        raw    = beat_raw(a, sz, k);
        b.addr = align(raw, sz);
        b.be   = lanes(raw, sz);
        b.wr   = rw;
        b.wd   = rw ? d : 32'h0;
        exp_beats.push_back(b);
        if (!rw) exp_resp.push_back({bad && (k == eb), (k == cnt) || (bad && (k == eb)), d});
      end
    end
    if (rw) exp_resp.push_back({bad, 1'b1, 32'h0});
  endtask

  // One clock: drive inputs at negedge, then score what the DUT does at the next posedge.
  task automatic cycle();
    beat_t b;
    @(negedge clk);
    bus.rempty      = (f1.size() == 0) || (rnd_gap && ($urandom_range(3) == 0));
    bus.rdata_fifo1 = (f1.size() != 0) ? f1[0] : 41'h0;
    bus.busy        = force_busy || (rnd_busy && ($urandom_range(2) == 0));
    bus.wfull       = (full_left > 0) || (rnd_full && ($urandom_range(3) == 0));
    if (full_left > 0) full_left--;
    bus.error       = (beat_cnt == err_beat);
    bus.rdata_aft   = (beat_cnt < rd_vals.size()) ? rd_vals[beat_cnt] : 32'h0;
    #1;
    check("winc_while_full", 64'(bus.winc & bus.wfull), 64'd0);
    if (bus.rinc) void'(f1.pop_front());
    if ((bus.ren || bus.wen) && !bus.busy) begin
      if (exp_beats.size() == 0) begin
        check("extra_beat", 64'(bus.addr_aft), 64'hFFFF_FFFF_FFFF);
      end else begin
        b = exp_beats.pop_front();
        check("beat_addr", 64'(bus.addr_aft), 64'(b.addr));
        check("beat_be", 64'(bus.byte_en), 64'(b.be));
        check("beat_wen", 64'(bus.wen), 64'(b.wr));
        if (b.wr) check("beat_wdata", 64'(bus.wdata_aft), 64'(b.wd));
      end
      beat_cnt++;
    end
    if (bus.winc) begin
      if (exp_resp.size() == 0) check("extra_resp", 64'(bus.wdata_fifo2), 64'hFFFF_FFFF_FFFF);
      else check("resp", 64'(bus.wdata_fifo2), 64'(exp_resp.pop_front()));
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    forever begin
      cycle();
      @(posedge clk);
      #1;
      n++;
      if ((f1.size() == 0) && !bus.ap_active) break;
      if (n >= budget) begin
        check("timeout", 64'(n), 64'(budget + 1));
        break;
      end
    end
    check("beats_left", 64'(exp_beats.size()), 64'd0);
    check("resp_left", 64'(exp_resp.size()), 64'd0);
    check("proto_err", 64'(bus.proto_err), 64'(exp_perr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    f1.delete();
    exp_beats.delete();
    exp_resp.delete();
    exp_perr = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    int eb;
    rst             = 1'b1;
    bus.rempty      = 1'b1;
    bus.rdata_fifo1 = '0;
    bus.wfull       = 1'b0;
    bus.busy        = 1'b0;
    bus.rdata_aft   = '0;
    bus.error       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", 64'({bus.rinc, bus.winc, bus.ren, bus.wen, bus.ap_active, bus.proto_err}),
          64'd0);
    check("reset_data", 64'({bus.byte_en, bus.wdata_fifo2}), 64'd0);
    check("reset_addr", 64'({bus.addr_aft, bus.wdata_aft}), 64'd0);
    rst = 1'b0;

    // Single word read with latency checks.
    expect_cmd(32'h1000, 2'b10, 0, 1'b0, -1);
    rd_vals[0]  = 32'hDEADBEEF;
    exp_resp[0] = {2'b01, 32'hDEADBEEF};
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.rinc && n < 10);
    cycle();
    check("setup_to_ren", 64'(bus.ren), 64'd1);
    cycle();
    check("xfer_to_winc", 64'(bus.winc), 64'd1);
    wait_idle(50);

    // Halfword write burst from 0x2002 with stalls.
    rnd_busy = 1;
    expect_cmd(32'h2002, 2'b01, 3, 1'b1, -1);
    wait_idle(200);
    rnd_busy = 0;

    // Word read burst wrapping at the 1KB boundary.
    expect_cmd(32'h13F8, 2'b10, 2, 1'b0, -1);
    wait_idle(100);

    // Write burst with a bus error on the second beat; remaining data drained.
    expect_cmd(32'h2400, 2'b10, 3, 1'b1, 1);
    wait_idle(100);

    // Read burst with the response FIFO full for a while.
    full_left = 8;
    expect_cmd(32'h5000, 2'b10, 1, 1'b0, -1);
    wait_idle(100);

    // Stray data word in IDLE.
    f1.push_back(data_w(32'h1234_5678));
    exp_perr = 1'b1;
    wait_idle(20);

    // Setup arriving while write data is awaited: first burst dropped, second runs.
    f1.push_back(setup_w(32'h4000, 2'b10, 1, 1'b1));
    expect_cmd(32'h4100, 2'b00, 2, 1'b0, -1);
    wait_idle(100);

    // Asynchronous reset in the middle of a stalled transfer.
    force_busy = 1;
    err_beat = -1;
    beat_cnt = 0;
    f1.push_back(setup_w(32'h3000, 2'b10, 0, 1'b0));
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.ren && n < 10);
    check("ren_before_rst", 64'(bus.ren), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_drop", 64'({bus.ren, bus.wen, bus.winc, bus.rinc, bus.ap_active}), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    force_busy = 0;
    f1.delete();
    exp_beats.delete();
    exp_resp.delete();
    exp_perr = 1'b0;
    wait_idle(10);

    // Randomised commands under random empty/busy/full pressure.
    rnd_gap  = 1;
    rnd_busy = 1;
    rnd_full = 1;
    for (int i = 0; i < 40; i++) begin
      cnt = $urandom_range(7);
      eb  = ($urandom_range(3) == 0) ? int'($urandom_range(cnt)) : -1;
      expect_cmd($urandom, 2'($urandom_range(3)), cnt, 1'($urandom_range(1)), eb);
      wait_idle(500);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
